// File: rtl/feg_ctrl_seq_if.sv
// Sequencer bus bundle: run control, imem fetch, ALU command, register file and data memory.
interface feg_ctrl_seq_if #(
  parameter int unsigned PC_W = 10
);
  logic            start;
  logic            done;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd_en;
  logic [8:0]      imem_data;
  logic            imem_valid;
  logic [2:0]      alu_cmd;
  logic [1:0]      immed;
  logic            direct;
  logic [1:0]      ra_addr;
  logic [1:0]      rb_addr;
  logic            br_logic;
  logic            rf_we;
  logic [1:0]      rf_waddr;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic [15:0]     instr_count;

  modport master (
    input  start, imem_data, imem_valid, br_logic, dmem_ack,
    output done, imem_addr, imem_rd_en, alu_cmd, immed, direct, ra_addr, rb_addr,
           rf_we, rf_waddr, dmem_req, dmem_we, instr_count
  );

  modport slave (
    output start, imem_data, imem_valid, br_logic, dmem_ack,
    input  done, imem_addr, imem_rd_en, alu_cmd, immed, direct, ra_addr, rb_addr,
           rf_we, rf_waddr, dmem_req, dmem_we, instr_count
  );
endinterface

// File: rtl/feg_ctrl_seq.sv
// FEG instruction sequencer: fetch, decode to ALU/regfile/dmem controls, branch resolution.
// Optional retired-instruction counter built when FEG_INSTR_COUNT_EN is defined.
module feg_ctrl_seq #(
  parameter int unsigned PC_W = 10
) (
  input logic            Clk,
  input logic            Reset,
  feg_ctrl_seq_if.master bus
);
  localparam int unsigned IR_W  = 9;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OFF_W = 6;

  localparam logic [2:0] OP_LDR   = 3'd0;
  localparam logic [2:0] OP_STR   = 3'd1;
  localparam logic [2:0] OP_MOV   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_SHIFT = 3'd5;
  localparam logic [2:0] OP_CMP   = 3'd6;
  localparam logic [2:0] OP_BR    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e          r_state,  w_state_nxt;
  logic [PC_W-1:0] r_pc,     w_pc_nxt;
  logic            r_flag,   w_flag_nxt;
  logic [IR_W-1:0] r_ir,     w_ir_nxt;

  logic            r_done,   w_done_nxt;
  logic            r_rd_en,  w_rd_en_nxt;
  logic [2:0]      r_alu_cmd, w_alu_cmd_nxt;
  logic [1:0]      r_immed,  w_immed_nxt;
  logic            r_direct, w_direct_nxt;
  logic [1:0]      r_ra,     w_ra_nxt;
  logic [1:0]      r_rb,     w_rb_nxt;
  logic [1:0]      r_waddr,  w_waddr_nxt;
  logic            r_dreq,   w_dreq_nxt;
  logic            r_dwe,    w_dwe_nxt;
  logic            w_rf_we;
  logic            w_bundle_on;

  logic [2:0]      w_op;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_br_off;

  assign w_op     = r_ir[8:6];
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_br_off = {{(PC_W-OFF_W){r_ir[OFF_W-1]}}, r_ir[OFF_W-1:0]};

  // Next-state, architectural updates and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flag_nxt  = r_flag;
    w_ir_nxt    = r_ir;
    w_rf_we     = 1'b0;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          w_pc_nxt    = '0;
          w_flag_nxt  = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.imem_valid) begin
          w_ir_nxt    = bus.imem_data;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_op)
          OP_LDR, OP_STR: w_state_nxt = S_MEM;
          OP_CMP: begin
            w_flag_nxt  = bus.br_logic;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
          OP_BR: begin
            if (r_ir[OFF_W-1:0] == '0) begin
              w_state_nxt = S_HALT;
            end else begin
              w_state_nxt = S_FETCH;
              if (r_flag) begin
                w_pc_nxt   = r_pc + w_br_off;
                w_flag_nxt = 1'b0;
              end else begin
                w_pc_nxt = w_pc_inc;
              end
            end
          end
          default: begin
            w_rf_we     = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          w_rf_we     = (w_op == OP_LDR);
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered so they line up with the state they describe
    w_bundle_on   = (w_state_nxt == S_EXEC) || (w_state_nxt == S_MEM);
    w_done_nxt    = (w_state_nxt == S_HALT);
    w_rd_en_nxt   = (w_state_nxt == S_FETCH);
    w_alu_cmd_nxt = w_bundle_on ? w_ir_nxt[8:6] : 3'b111;
    w_immed_nxt   = w_bundle_on ? w_ir_nxt[3:2] : 2'b00;
    w_direct_nxt  = w_bundle_on ? w_ir_nxt[1]   : 1'b0;
    w_ra_nxt      = w_ir_nxt[5:4];
    w_rb_nxt      = w_ir_nxt[3:2];
    w_waddr_nxt   = w_ir_nxt[5:4];
    w_dreq_nxt    = (w_state_nxt == S_MEM);
    w_dwe_nxt     = (w_state_nxt == S_MEM) && (w_ir_nxt[8:6] == OP_STR);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_flag    <= 1'b0;
      r_ir      <= '0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_cmd <= 3'b111;
      r_immed   <= 2'b00;
      r_direct  <= 1'b0;
      r_ra      <= 2'b00;
      r_rb      <= 2'b00;
      r_waddr   <= 2'b00;
      r_dreq    <= 1'b0;
      r_dwe     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_flag    <= w_flag_nxt;
      r_ir      <= w_ir_nxt;
      r_done    <= w_done_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_alu_cmd <= w_alu_cmd_nxt;
      r_immed   <= w_immed_nxt;
      r_direct  <= w_direct_nxt;
      r_ra      <= w_ra_nxt;
      r_rb      <= w_rb_nxt;
      r_waddr   <= w_waddr_nxt;
      r_dreq    <= w_dreq_nxt;
      r_dwe     <= w_dwe_nxt;
    end
  end

  assign bus.done       = r_done;
  assign bus.imem_addr  = r_pc;
  assign bus.imem_rd_en = r_rd_en;
  assign bus.alu_cmd    = r_alu_cmd;
  assign bus.immed      = r_immed;
  assign bus.direct     = r_direct;
  assign bus.ra_addr    = r_ra;
  assign bus.rb_addr    = r_rb;
  assign bus.rf_waddr   = r_waddr;
  assign bus.dmem_req   = r_dreq;
  assign bus.dmem_we    = r_dwe;
  // Write strobe follows the ack combinationally so LDR writes on the ack cycle
  assign bus.rf_we      = w_rf_we;

`ifdef FEG_INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;
  logic             w_cnt_clr;

  assign w_retire  = ((r_state == S_EXEC) && (w_state_nxt != S_MEM)) ||
                     ((r_state == S_MEM) && bus.dmem_ack);
  assign w_cnt_clr = bus.start && ((r_state == S_IDLE) || (r_state == S_HALT));

  always_ff @(posedge Clk) begin
    if (Reset || w_cnt_clr) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign bus.instr_count = r_instr_count;
`else
  assign bus.instr_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_feg_ctrl_seq.sv
// Directed + randomized bench for feg_ctrl_seq against an instruction-level reference model.
module tb_feg_ctrl_seq;
  localparam int unsigned PC_W   = 10;
  localparam int          PC_MOD = 1 << PC_W;

  logic Clk = 1'b0;
  logic Reset;

  feg_ctrl_seq_if #(.PC_W(PC_W)) bus ();
  feg_ctrl_seq #(.PC_W(PC_W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Architectural reference state
  int m_pc   = 0;
  bit m_flag = 1'b0;
  int m_cnt  = 0;
  bit cnt_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt();
    return cnt_en ? 32'(m_cnt % 65536) : 32'd0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_alu_cmd"}, 32'(bus.alu_cmd), 32'd7);
    check({tag, "_immed"},   32'(bus.immed),   32'd0);
    check({tag, "_direct"},  32'(bus.direct),  32'd0);
    check({tag, "_rf_we"},   32'(bus.rf_we),   32'd0);
    check({tag, "_dreq"},    32'(bus.dmem_req), 32'd0);
    check({tag, "_dwe"},     32'(bus.dmem_we), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_quiet(tag);
    check({tag, "_done"},  32'(bus.done),        32'd0);
    check({tag, "_rden"},  32'(bus.imem_rd_en),  32'd0);
    check({tag, "_addr"},  32'(bus.imem_addr),   32'd0);
    check({tag, "_ra"},    32'(bus.ra_addr),     32'd0);
    check({tag, "_rb"},    32'(bus.rb_addr),     32'd0);
    check({tag, "_waddr"}, 32'(bus.rf_waddr),    32'd0);
    check({tag, "_cnt"},   32'(bus.instr_count), 32'd0);
  endtask

  task automatic check_fetch(input string tag);
    check_quiet(tag);
    check({tag, "_rden"}, 32'(bus.imem_rd_en),  32'd1);
    check({tag, "_done"}, 32'(bus.done),        32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr),   32'(m_pc));
    check({tag, "_cnt"},  32'(bus.instr_count), exp_cnt());
  endtask

  task automatic check_halt(input string tag);
    check_quiet(tag);
    check({tag, "_done"}, 32'(bus.done),        32'd1);
    check({tag, "_rden"}, 32'(bus.imem_rd_en),  32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr),   32'(m_pc));
    check({tag, "_cnt"},  32'(bus.instr_count), exp_cnt());
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_pc = 0; m_flag = 1'b0; m_cnt = 0;
    check_fetch("start");
  endtask

  // Runs one instruction from FETCH to retirement; iw = imem wait cycles, aw = dmem ack delay
  task automatic exec_instr(input logic [8:0] instr, input int iw, input int aw, input bit br);
    int   op;
    int   off;
    bit   alu_wr;
    op     = int'(instr[8:6]);
    off    = int'(instr[5:0]);
    alu_wr = (op >= 2) && (op <= 5);
    for (int w = 0; w < iw; w++) begin
      bus.imem_valid = 1'b0;
      bus.imem_data  = 9'($urandom);
      bus.start      = (w == 0);
      bus.dmem_ack   = 1'($urandom);
      tick();
      bus.start    = 1'b0;
      bus.dmem_ack = 1'b0;
      #1;
      check_fetch("fetch_wait");
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = instr;
    bus.br_logic   = br;
    tick();
    // Stray valid/ack in EXEC must be ignored
    bus.imem_valid = 1'b1;
    bus.imem_data  = 9'($urandom);
    bus.dmem_ack   = 1'b1;
    #1;
    check("exec_alu_cmd", 32'(bus.alu_cmd),  32'(op));
    check("exec_immed",   32'(bus.immed),    32'(instr[3:2]));
    check("exec_direct",  32'(bus.direct),   32'(instr[1]));
    check("exec_ra",      32'(bus.ra_addr),  32'(instr[5:4]));
    check("exec_rb",      32'(bus.rb_addr),  32'(instr[3:2]));
    check("exec_waddr",   32'(bus.rf_waddr), 32'(instr[5:4]));
    check("exec_rf_we",   32'(bus.rf_we),    32'(alu_wr));
    check("exec_dreq",    32'(bus.dmem_req), 32'd0);
    check("exec_rden",    32'(bus.imem_rd_en), 32'd0);
    tick();
    bus.imem_valid = 1'b0;
    bus.dmem_ack   = 1'b0;
    if (op <= 1) begin
      for (int k = 0; k <= aw; k++) begin
        bus.dmem_ack = (k == aw);
        #1;
        check("mem_dreq",    32'(bus.dmem_req), 32'd1);
        check("mem_dwe",     32'(bus.dmem_we),  32'(op == 1));
        check("mem_alu_cmd", 32'(bus.alu_cmd),  32'(op));
        check("mem_immed",   32'(bus.immed),    32'(instr[3:2]));
        check("mem_rf_we",   32'(bus.rf_we),    32'((op == 0) && (k == aw)));
        tick();
      end
      bus.dmem_ack = 1'b0;
      m_pc = (m_pc + 1) % PC_MOD;
    end else if (op == 6) begin
      m_flag = br;
      m_pc   = (m_pc + 1) % PC_MOD;
    end else if (op == 7) begin
      if (off != 0) begin
        if (m_flag) begin
          if (off >= 32) off = off - 64;
          m_pc   = (m_pc + PC_MOD + off) % PC_MOD;
          m_flag = 1'b0;
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
    m_cnt++;
    if ((op == 7) && (off == 0)) check_halt("halt");
    else                         check_fetch("next_fetch");
  endtask

  function automatic logic [8:0] rand_instr();
    logic [2:0] op;
    logic [5:0] body;
    op   = 3'($urandom_range(0, 7));
    body = 6'($urandom_range(0, 63));
    if ((op == 3'd7) && (body == 6'd0)) body = 6'd1;
    return {op, body};
  endfunction

  initial begin
`ifdef FEG_INSTR_COUNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    bus.start = 1'b0; bus.imem_valid = 1'b0; bus.imem_data = '0;
    bus.br_logic = 1'b0; bus.dmem_ack = 1'b0;

    // Reset wins over a simultaneous start
    Reset = 1'b1; bus.start = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    check_reset("reset");
    Reset = 1'b0;
    tick();
    check_reset("idle");

    // MOV r1,#3 with same-cycle valid, then a short branch program
    do_start();
    exec_instr(9'b010_01_11_0_0, 0, 0, 1'b0);
    check("mov_next_addr", 32'(bus.imem_addr), 32'd1);
    for (int i = 0; i < 3; i++) exec_instr({3'b011, 6'($urandom)}, 0, 0, 1'b0);
    exec_instr(9'b110_000000, 0, 0, 1'b1);
    exec_instr(9'b111_111100, 0, 0, 1'b0);
    check("br_taken_pc", 32'(bus.imem_addr), 32'd1);
    for (int i = 0; i < 3; i++) exec_instr({3'b100, 6'($urandom)}, 0, 0, 1'b1);
    exec_instr(9'b110_000000, 0, 0, 1'b0);
    exec_instr(9'b111_111100, 0, 0, 1'b1);
    check("br_not_taken_pc", 32'(bus.imem_addr), 32'd6);

    // Memory ops with delayed ack, then a long imem stall
    exec_instr(9'b000_10_01_0_0, 0, 3, 1'b0);
    exec_instr(9'b001_11_10_0_0, 0, 2, 1'b0);
    exec_instr(9'b101_01_10_1_0, 5, 0, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++)
      exec_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));

    // HALT held, then restart
    exec_instr(9'b111_000000, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_halt("halt_hold");
    end
    do_start();

    // Four instructions then HALT retire five
    for (int i = 0; i < 4; i++) exec_instr({3'b011, 6'($urandom)}, 1, 0, 1'b0);
    exec_instr(9'b111_000000, 0, 0, 1'b0);
    check("count_after_halt", 32'(bus.instr_count), cnt_en ? 32'd5 : 32'd0);

    // Reset with a data memory request outstanding
    do_start();
    bus.imem_valid = 1'b1; bus.imem_data = 9'b000_01_01_0_0;
    tick();
    bus.imem_valid = 1'b0;
    tick();
    #1;
    check("mid_mem_dreq", 32'(bus.dmem_req), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset("reset_mid_mem");
    tick();
    check_reset("idle_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/feg_ctrl_seq.md
# feg_ctrl_seq

Instruction sequencer for the FEG processor: fetches 9-bit instructions from instruction memory over a valid handshake, decodes them into the ALU command bundle (`alu_cmd`, `immed`, `direct`) and register/data-memory controls, and consumes the ALU's `br_logic` result to resolve branches. It is the command-producing end of the ALU interface. It sits between instruction memory, the register file, data memory and the ALU.

## Interface
- `PC_W`, default 10: program counter width; imem depth 2^PC_W.
- `Clk`  in  1  single clock, all state on rising edge.
- `Reset`  in  1  synchronous, active-high; returns the block to IDLE.
- `start`  in  1  single-cycle pulse; begins execution at PC 0 from IDLE or HALT.
- `done`  out  1  high while in HALT.
- `imem_addr`  out  PC_W  current PC.
- `imem_rd_en`  out  1  fetch request, high throughout FETCH.
- `imem_data`  in  9  instruction word, sampled when `imem_valid`.
- `imem_valid`  in  1  instruction present; may assert in the same cycle as `imem_rd_en`.
- `alu_cmd`  out  3  ALU opcode = `instr[8:6]`.
- `immed`  out  2  `instr[3:2]`.
- `direct`  out  1  `instr[1]` (1 = right shift).
- `ra_addr`, `rb_addr`  out  2 each  register read addresses `instr[5:4]`, `instr[3:2]`.
- `br_logic`  in  1  ALU equality result, sampled during CMP EXEC.
- `rf_we`  out  1  register write strobe; `rf_waddr` out 2 = `instr[5:4]`.
- `dmem_req`, `dmem_we`  out  1 each  data memory request / write qualifier.
- `dmem_ack`  in  1  data memory completion.
- `instr_count`  out  16  retired-instruction count (see Configuration).

## Operation
- Opcodes: 000 LDR, 001 STR, 010 MOV, 011 XOR, 100 AND, 101 SHIFT, 110 CMP, 111 BR. BR offset = `instr[5:0]`, two's complement.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE: on `start`, PC←0, flag←0, go to FETCH.
- FETCH: `imem_rd_en`=1; hold until `imem_valid`; latch `imem_data` into the instruction register; go to EXEC.
- EXEC drives the decoded bundle from the instruction register:
  - MOV/XOR/AND/SHIFT: `rf_we`=1 this cycle, PC←PC+1, go to FETCH.
  - CMP: flag←`br_logic`, PC←PC+1, go to FETCH.
  - LDR/STR: go to MEM.
  - BR with offset 0: HALT instruction, go to HALT with PC unchanged.
  - BR with a nonzero offset: if flag, PC←PC+sext(offset) and flag←0; else PC←PC+1. Go to FETCH.
- MEM: `dmem_req`=1, `dmem_we`=(op==STR), bundle held stable; wait for `dmem_ack`.
  - On the ack cycle: LDR asserts `rf_we`; PC←PC+1; go to FETCH.
- HALT: `done`=1; `start` restarts as from IDLE.
- Outside EXEC/MEM: `alu_cmd`=3'b111, `immed`=0, `direct`=0, `rf_we`=0, `dmem_req`=0, `dmem_we`=0.
- PC arithmetic is modulo 2^PC_W; increment and branch wrap silently.

## Timing
- Reset values: `done`=0, `imem_rd_en`=0, `imem_addr`=0, `alu_cmd`=3'b111, `immed`=0, `direct`=0, `ra_addr`=0, `rb_addr`=0, `rf_we`=0, `rf_waddr`=0, `dmem_req`=0, `dmem_we`=0, `instr_count`=0; internal flag=0, PC=0.
- ALU/CMP/BR instruction: 2 cycles with zero-wait imem (FETCH + EXEC); each imem wait cycle adds 1.
- LDR/STR: 3 cycles minimum (FETCH, EXEC, MEM with same-cycle ack).
- `start` outside IDLE/HALT is ignored. `imem_valid` outside FETCH and `dmem_ack` outside MEM are ignored.
- `Reset` in any state, including mid-MEM with a request outstanding, returns to IDLE next edge. All strobes deassert and the request is abandoned.
- `Reset` and `start` in the same cycle: `Reset` wins.

## Configuration
- `FEG_INSTR_COUNT_EN` defined: `instr_count` increments by 1, wrapping at 16 bits, each time an instruction retires. Retirement is the EXEC exit to FETCH/HALT, or the MEM ack. The count clears on `Reset` and on `start`.
- `FEG_INSTR_COUNT_EN` undefined: the counter is not built and `instr_count` is tied to 0.

## Test plan
- Reset, `start`, imem returns 9'b010_01_11_0_0 (MOV r1,#3) with same-cycle valid -> EXEC at cycle 2 shows `alu_cmd`=010, `immed`=3, `rf_we`=1, `rf_waddr`=1; next fetch at `imem_addr`=1.
- CMP with `br_logic`=1 then BR offset 6'b111100 at PC 5 -> PC becomes 1, flag cleared. Repeating with `br_logic`=0 -> PC becomes 6.
- LDR with `dmem_ack` delayed 3 cycles -> `dmem_req` high 4 cycles, `dmem_we`=0, `rf_we` only on the ack cycle. STR variant -> `dmem_we`=1, no `rf_we`.
- `imem_valid` withheld 5 cycles -> `imem_rd_en` and `imem_addr` stable, no EXEC strobes.
- BR offset 0 -> `done`=1 and held. `start` -> `done`=0, `imem_addr`=0. `Reset` asserted mid-MEM -> IDLE with all outputs at reset values.
- With `FEG_INSTR_COUNT_EN` defined: 4 instructions then HALT -> `instr_count`=5. Undefined -> `instr_count`=0 throughout.
